// File: rtl/serial_rx.sv
// serial_rx: resynchronises a transmission/clock/data serial stream into clk and deserialises WIDTH-bit words.
// Optional even-parity checking per word is enabled by defining SERIAL_RX_PARITY_EN.
module serial_rx #(
  parameter int WIDTH       = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             transmission,
  input  logic             clock,
  input  logic             data,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [7:0]       word_count
);

`ifdef SERIAL_RX_PARITY_EN
  localparam int NSTB = WIDTH + 1;
`else
  localparam int NSTB = WIDTH;
`endif
  localparam int CW = $clog2(NSTB + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  logic [SYNC_STAGES-1:0] tx_sync_reg, ck_sync_reg, d_sync_reg;
  logic                   tx_s, ck_s, d_s, bit_stb;
  logic                   ck_prev_reg, stb_reg, bit_reg, tx_reg, armed_reg;
  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [WIDTH-1:0]       sr_reg, sr_next, sr_shift, assembled;
  logic [WIDTH-1:0]       word_reg, word_next;
  logic                   valid_reg, valid_next, err_reg, err_next, busy_reg, busy_next;
  logic [7:0]             count_reg, count_next;
  logic                   done, good;

  assign tx_s    = tx_sync_reg[SYNC_STAGES-1];
  assign ck_s    = ck_sync_reg[SYNC_STAGES-1];
  assign d_s     = d_sync_reg[SYNC_STAGES-1];
  assign bit_stb = ck_s & ~ck_prev_reg;

  // The frame-enable synchroniser resets high so a receiver released while
  // transmission is already high waits for a genuine low-to-high frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sync_reg <= '1;
      ck_sync_reg <= '0;
      d_sync_reg  <= '0;
      ck_prev_reg <= 1'b0;
      stb_reg     <= 1'b0;
      bit_reg     <= 1'b0;
      tx_reg      <= 1'b1;
      armed_reg   <= 1'b0;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      sr_reg      <= '0;
      word_reg    <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      count_reg   <= '0;
    end else begin
      tx_sync_reg <= {tx_sync_reg[SYNC_STAGES-2:0], transmission};
      ck_sync_reg <= {ck_sync_reg[SYNC_STAGES-2:0], clock};
      d_sync_reg  <= {d_sync_reg[SYNC_STAGES-2:0], data};
      ck_prev_reg <= ck_s;
      // Strobe, bit value and frame enable are re-registered together so the
      // FSM always sees them aligned on the same cycle.
      stb_reg     <= bit_stb;
      bit_reg     <= d_s;
      tx_reg      <= tx_s;
      armed_reg   <= armed_reg | ~tx_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      sr_reg      <= sr_next;
      word_reg    <= word_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
      busy_reg    <= busy_next;
      count_reg   <= count_next;
    end
  end

  assign sr_shift = MSB_FIRST ? {sr_reg[WIDTH-2:0], bit_reg} : {bit_reg, sr_reg[WIDTH-1:1]};
  assign done     = stb_reg && (cnt_reg == CW'(NSTB - 1));

`ifdef SERIAL_RX_PARITY_EN
  logic par_reg, par_next;

  // Running XOR of the data bits; the final strobe carries the parity bit.
  always_comb begin
    par_next = par_reg;
    if (done)
      par_next = 1'b0;
    else if (state_reg != SHIFT)
      par_next = stb_reg & bit_reg;
    else if (stb_reg)
      par_next = par_reg ^ bit_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_reg <= 1'b0;
    else     par_reg <= par_next;
  end

  assign good      = ~(par_reg ^ bit_reg);
  assign assembled = sr_reg;
`else
  assign good      = 1'b1;
  assign assembled = sr_shift;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sr_next    = sr_reg;
    word_next  = word_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (tx_reg && armed_reg) begin
          state_next = SHIFT;
          cnt_next   = '0;
          if (stb_reg) begin
            sr_next  = sr_shift;
            cnt_next = CW'(1);
          end
        end
      end
      SHIFT: begin
        if (done) begin
          cnt_next = '0;
          sr_next  = sr_shift;
          if (good) begin
            word_next  = assembled;
            valid_next = 1'b1;
            count_next = count_reg + 8'd1;
          end else begin
            err_next = 1'b1;
          end
          if (!tx_reg)
            state_next = IDLE;
`ifdef SERIAL_RX_PARITY_EN
          else if (!good)
            state_next = DRAIN;
`endif
        end else if (!tx_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
          err_next   = (cnt_reg != '0);
        end else if (stb_reg) begin
          sr_next  = sr_shift;
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DRAIN: begin
        if (!tx_reg)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == SHIFT);
  end

  assign word       = word_reg;
  assign word_valid = valid_reg;
  assign frame_err  = err_reg;
  assign busy       = busy_reg;
  assign word_count = count_reg;

endmodule

// File: tb/tb_serial_rx.sv
// Randomised self-checking bench for serial_rx: one stream drives an MSB-first (3-stage sync)
// and an LSB-first (2-stage sync) receiver, each compared against a bit-list reference model.
module tb_serial_rx;
  logic       clk = 1'b0;
  logic       rst, transmission, clock, data;
  logic [7:0] word_m, word_l, cnt_m, cnt_l;
  logic       valid_m, valid_l, err_m, err_l, busy_m, busy_l;

  serial_rx #(.WIDTH(8), .MSB_FIRST(1'b1), .SYNC_STAGES(3)) u_msb (
    .clk(clk), .rst(rst), .transmission(transmission), .clock(clock), .data(data),
    .word(word_m), .word_valid(valid_m), .frame_err(err_m), .busy(busy_m), .word_count(cnt_m));

  serial_rx #(.WIDTH(8), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_lsb (
    .clk(clk), .rst(rst), .transmission(transmission), .clock(clock), .data(data),
    .word(word_l), .word_valid(valid_l), .frame_err(err_l), .busy(busy_l), .word_count(cnt_l));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0, rise_cyc = 0;
  int vcnt_m = 0, vcnt_l = 0, ecnt_m = 0, ecnt_l = 0, vcyc_m = 0, vcyc_l = 0;
  int exp_vcnt = 0, exp_ecnt = 0, exp_cnt = 0;
  logic [7:0] exp_word_m = 0, exp_word_l = 0;
  bit busy_win = 0, busy_drop = 0, fixed4 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters count high cycles, so a pulse wider than one clk shows up as an extra count.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_m) begin vcnt_m <= vcnt_m + 1; vcyc_m <= cyc; end
      if (valid_l) begin vcnt_l <= vcnt_l + 1; vcyc_l <= cyc; end
      if (err_m) ecnt_m <= ecnt_m + 1;
      if (err_l) ecnt_l <= ecnt_l + 1;
      if (busy_win && !(busy_m && busy_l)) busy_drop <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Reference: word value implied by the ordered list of received bits.
  function automatic logic [7:0] model(input logic [31:0] seq, input bit msb);
    int v = 0;
    for (int i = 0; i < 8; i++)
      v = msb ? (v * 2 + int'(seq[i])) : (v + (int'(seq[i]) << i));
    return v[7:0];
  endfunction

  function automatic logic [31:0] msb_seq(input logic [7:0] val);
    logic [31:0] s = 0;
    for (int i = 0; i < 8; i++) s[i] = val[7-i];
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic phase();
    tick(fixed4 ? 4 : $urandom_range(4, 6));
  endtask

  task automatic send_bit(input logic b, input bit drop);
    data = b;
    phase();
    clock = 1'b1;
    rise_cyc = cyc;
    if (drop) transmission = 1'b0;
    phase();
    clock = 1'b0;
  endtask

  task automatic send_data(input logic [31:0] seq, input int n, input bit drop_last, input bit flip_par);
    bit last;
    logic p;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
`ifdef SERIAL_RX_PARITY_EN
      if (n == 8) last = 0;
`endif
      send_bit(seq[i], drop_last && last);
    end
`ifdef SERIAL_RX_PARITY_EN
    if (n == 8) begin
      p = (^seq[7:0]) ^ flip_par;
      send_bit(p, drop_last);
    end
`else
    p = flip_par;
`endif
  endtask

  task automatic expect_good(input logic [31:0] seq);
    exp_word_m = model(seq, 1'b1);
    exp_word_l = model(seq, 1'b0);
    exp_vcnt++;
    exp_cnt++;
  endtask

  task automatic verify(input string tag);
    check({tag, "_word_m"}, word_m, exp_word_m);
    check({tag, "_word_l"}, word_l, exp_word_l);
    check({tag, "_count_m"}, cnt_m, exp_cnt % 256);
    check({tag, "_count_l"}, cnt_l, exp_cnt % 256);
    check({tag, "_valids_m"}, vcnt_m, exp_vcnt);
    check({tag, "_valids_l"}, vcnt_l, exp_vcnt);
    check({tag, "_errs_m"}, ecnt_m, exp_ecnt);
    check({tag, "_errs_l"}, ecnt_l, exp_ecnt);
  endtask

  task automatic frame(input string tag, input logic [31:0] seq);
    transmission = 1'b1;
    tick(8);
    send_data(seq, 8, 1'b0, 1'b0);
    tick(6);
    transmission = 1'b0;
    tick(10);
    expect_good(seq);
    verify(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_word_m"}, word_m, 0);
    check({tag, "_word_l"}, word_l, 0);
    check({tag, "_outs_m"}, {valid_m, err_m, busy_m, cnt_m}, 0);
    check({tag, "_outs_l"}, {valid_l, err_l, busy_l, cnt_l}, 0);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout got=%0d exp=finish", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] seq;
    rst = 1'b1; transmission = 1'b0; clock = 1'b0; data = 1'b0;
    tick(3);
    check_zero("reset");
    rst = 1'b0;
    tick(8);

    frame("a5", msb_seq(8'hA5));
    check("a5_literal", word_m, 8'hA5);

    // Back-to-back words with transmission held high; LSB-first receiver sees the named values.
    transmission = 1'b1;
    tick(8);
    busy_win = 1;
    for (int k = 0; k < 3; k++) begin
      seq = (k == 0) ? 32'h3C : (k == 1) ? 32'hFF : 32'h00;
      send_data(seq, 8, 1'b0, 1'b0);
      tick(4);
      expect_good(seq);
      verify("b2b");
    end
    busy_win = 0;
    transmission = 1'b0;
    tick(10);
    check("b2b_busy_drop", busy_drop, 0);
    check("b2b_lsb_3c_ff_00_last", word_l, 8'h00);

    // Framing error: frame enable drops after five bits.
    transmission = 1'b1;
    tick(8);
    send_data(msb_seq(8'h81), 5, 1'b0, 1'b0);
    tick(6);
    transmission = 1'b0;
    tick(10);
    exp_ecnt++;
    verify("ferr");
    frame("ferr_retry", msb_seq(8'h81));

    // Frame enable falls on the same edge as the final serial clock rise.
    seq = msb_seq(8'h5A);
    transmission = 1'b1;
    tick(8);
    send_data(seq, 8, 1'b1, 1'b0);
    tick(10);
    expect_good(seq);
    verify("simul");
    check("simul_busy_m", busy_m, 0);
    check("simul_busy_l", busy_l, 0);

    // Latency with minimum-length clock phases.
    fixed4 = 1;
    frame("lat", msb_seq(8'hC3));
    check("lat_edges_sync3", vcyc_m - rise_cyc, 5);
    check("lat_edges_sync2", vcyc_l - rise_cyc, 4);
    fixed4 = 0;

`ifdef SERIAL_RX_PARITY_EN
    frame("par_ok", msb_seq(8'h07));
    check("par_ok_literal", word_m, 8'h07);
    transmission = 1'b1;
    tick(8);
    send_data(msb_seq(8'h07), 8, 1'b0, 1'b1);
    send_data($urandom, 8, 1'b0, 1'b0);
    tick(6);
    transmission = 1'b0;
    tick(10);
    exp_ecnt++;
    verify("par_bad");
    frame("par_after", msb_seq(8'h3E));
`endif

    // Reset mid-bit while transmission stays high.
    transmission = 1'b1;
    tick(8);
    send_data(msb_seq(8'hF0), 3, 1'b0, 1'b0);
    clock = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    check_zero("rst_mid");
    tick(2);
    clock = 1'b0;
    rst = 1'b0;
    exp_cnt = 0; exp_word_m = 0; exp_word_l = 0;
    tick(6);
    send_data(msb_seq(8'h5F), 8, 1'b0, 1'b0);
    tick(6);
    transmission = 1'b0;
    tick(10);
    verify("rst_no_fresh_rise");
    frame("rst_a5", msb_seq(8'hA5));
    check("rst_a5_count", cnt_m, 1);

    // Random bursts of 1..3 back-to-back words.
    for (int f = 0; f < 12; f++) begin
      int nw;
      nw = $urandom_range(1, 3);
      transmission = 1'b1;
      tick(8);
      for (int k = 0; k < nw; k++) begin
        seq = $urandom & 32'hFF;
        send_data(seq, 8, 1'b0, 1'b0);
        tick(4);
        expect_good(seq);
        verify("rand");
      end
      transmission = 1'b0;
      tick(10);
    end
    check("rand_errs_m", ecnt_m, exp_ecnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
